// File: rtl/stream_demux2.sv
// Packet-locked 1:2 stream demultiplexer with one registered output slot per port.
// Optional per-port delivered-beat counters are enabled with STREAM_DEMUX2_CNT_EN.
module stream_demux2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_last,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_last,
  output logic             busy
`ifdef STREAM_DEMUX2_CNT_EN
  ,
  output logic [15:0]      a_count,
  output logic [15:0]      b_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_dest_b;
  logic   w_a_free;
  logic   w_b_free;
  logic   w_accept;
  logic   w_load_a;
  logic   w_load_b;

  // Destination is sampled from in_sel only on the first beat; later beats follow the lock.
  always_comb begin
    w_dest_b = 1'b0;
    if (r_state == IDLE) begin
      w_dest_b = in_sel;
    end else begin
      w_dest_b = (r_state == ROUTE_B);
    end
  end

  assign w_a_free = !a_valid || a_ready;
  assign w_b_free = !b_valid || b_ready;
  assign in_ready = w_dest_b ? w_b_free : w_a_free;
  assign w_accept = in_valid && in_ready;
  assign w_load_a = w_accept && !w_dest_b;
  assign w_load_b = w_accept && w_dest_b;

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (in_last) begin
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = w_dest_b ? ROUTE_B : ROUTE_A;
      end
    end
  end

  // State, output slots and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      a_valid <= 1'b0;
      a_data  <= '0;
      a_last  <= 1'b0;
      b_valid <= 1'b0;
      b_data  <= '0;
      b_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != IDLE);

      if (w_load_a) begin
        a_valid <= 1'b1;
        a_data  <= in_data;
        a_last  <= in_last;
      end else if (a_ready) begin
        a_valid <= 1'b0;
      end

      if (w_load_b) begin
        b_valid <= 1'b1;
        b_data  <= in_data;
        b_last  <= in_last;
      end else if (b_ready) begin
        b_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_DEMUX2_CNT_EN
  // Saturating counts of beats handed downstream on each port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_count <= 16'd0;
      b_count <= 16'd0;
    end else begin
      if (a_valid && a_ready && (a_count != 16'hFFFF)) begin
        a_count <= a_count + 16'd1;
      end
      if (b_valid && b_ready && (b_count != 16'hFFFF)) begin
        b_count <= b_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux2.sv
// Directed self-checking bench for stream_demux2 with hand-computed expectations.
// Counter checks are compiled in only when STREAM_DEMUX2_CNT_EN is defined.
`timescale 1ns/1ps
module tb_stream_demux2;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_sel;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             busy;
`ifdef STREAM_DEMUX2_CNT_EN
  logic [15:0]      a_count;
  logic [15:0]      b_count;
`endif

  int checks = 0;
  int errors = 0;

  stream_demux2 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .a_last   (a_last),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .b_last   (b_last),
    .busy     (busy)
`ifdef STREAM_DEMUX2_CNT_EN
    ,
    .a_count  (a_count),
    .b_count  (b_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d, input logic l);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    in_last  = l;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_sel   = 1'b0;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    #12;
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_a_data",  32'(a_data),  32'd0);
    check("rst_b_last",  32'(b_last),  32'd0);
    rst_n = 1'b1;
    tick();

    // Single-beat packet to b
    drive(1'b1, 1'b1, 8'h5A, 1'b1);
    check("sb_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("sb_b_valid", 32'(b_valid), 32'd1);
    check("sb_b_data",  32'(b_data),  32'h5A);
    check("sb_b_last",  32'(b_last),  32'd1);
    check("sb_a_valid", 32'(a_valid), 32'd0);
    check("sb_busy",    32'(busy),    32'd0);
    drive(1'b0, 1'b1, 8'hEE, 1'b1);
    tick();
    check("sb_drain_b_valid", 32'(b_valid), 32'd0);
    check("sb_noload_a_valid", 32'(a_valid), 32'd0);

    // Packet lock: in_sel toggles after first beat
    drive(1'b1, 1'b0, 8'h01, 1'b0);
    tick();
    check("pl1_a_valid", 32'(a_valid), 32'd1);
    check("pl1_a_data",  32'(a_data),  32'h01);
    check("pl1_a_last",  32'(a_last),  32'd0);
    check("pl1_busy",    32'(busy),    32'd1);
    drive(1'b1, 1'b1, 8'h02, 1'b0);
    tick();
    check("pl2_a_data",  32'(a_data),  32'h02);
    check("pl2_a_last",  32'(a_last),  32'd0);
    check("pl2_b_valid", 32'(b_valid), 32'd0);
    check("pl2_busy",    32'(busy),    32'd1);
    drive(1'b1, 1'b1, 8'h03, 1'b1);
    tick();
    check("pl3_a_data",  32'(a_data),  32'h03);
    check("pl3_a_last",  32'(a_last),  32'd1);
    check("pl3_b_valid", 32'(b_valid), 32'd0);
    check("pl3_busy",    32'(busy),    32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("pl_drain_a_valid", 32'(a_valid), 32'd0);

    // Backpressure on a, then zero-bubble refill
    a_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h11, 1'b1);
    tick();
    check("bp_a_valid", 32'(a_valid), 32'd1);
    check("bp_a_data",  32'(a_data),  32'h11);
    drive(1'b1, 1'b0, 8'h22, 1'b1);
    check("bp_in_ready_stall", 32'(in_ready), 32'd0);
    tick();
    check("bp_hold_a_data",  32'(a_data),  32'h11);
    check("bp_hold_a_valid", 32'(a_valid), 32'd1);
    a_ready = 1'b1;
    #1;
    check("bp_in_ready_free", 32'(in_ready), 32'd1);
    tick();
    check("bp_refill_a_valid", 32'(a_valid), 32'd1);
    check("bp_refill_a_data",  32'(a_data),  32'h22);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("bp_drain_a_valid", 32'(a_valid), 32'd0);

    // b stalled does not block a
    b_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h77, 1'b1);
    tick();
    check("ind_b_valid", 32'(b_valid), 32'd1);
    drive(1'b1, 1'b0, 8'h33, 1'b1);
    check("ind_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("ind_a_valid", 32'(a_valid), 32'd1);
    check("ind_a_data",  32'(a_data),  32'h33);
    check("ind_b_valid_held", 32'(b_valid), 32'd1);
    check("ind_b_data_held",  32'(b_data),  32'h77);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    b_ready = 1'b1;
    tick();
    check("ind_both_drain_a", 32'(a_valid), 32'd0);
    check("ind_both_drain_b", 32'(b_valid), 32'd0);

    // Reset in the middle of a 4-beat packet to b
    drive(1'b1, 1'b1, 8'hB1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'hB2, 1'b0);
    tick();
    check("mr_busy_before",   32'(busy),    32'd1);
    check("mr_b_data_before", 32'(b_data),  32'hB2);
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mr_busy",    32'(busy),    32'd0);
    check("mr_b_valid", 32'(b_valid), 32'd0);
    check("mr_b_data",  32'(b_data),  32'd0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'hC3, 1'b1);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("mr_a_valid", 32'(a_valid), 32'd1);
    check("mr_a_data",  32'(a_data),  32'hC3);
    check("mr_b_valid_after", 32'(b_valid), 32'd0);
    check("mr_busy_after",    32'(busy),    32'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();

`ifdef STREAM_DEMUX2_CNT_EN
    // Saturating counters
    rst_n = 1'b0;
    #2;
    check("cnt_rst_a", 32'(a_count), 32'd0);
    rst_n = 1'b1;
    tick();
    drive(1'b1, 1'b0, 8'hA5, 1'b1);
    for (int i = 0; i < 65537; i++) begin
      @(posedge clk);
    end
    #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    check("cnt_a_sat", 32'(a_count), 32'd65535);
    check("cnt_b_zero", 32'(b_count), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
